// File: rtl/regfile_write_queue.sv
// In-order writeback queue feeding the register file write port, with decode-side forwarding lookup.
// Latency: an accept at edge N drives reg_write/write_reg/write_data from edge N+1; lookups are combinational.
// Backpressure: in_ready drops only while count == DEPTH; a same-cycle pop never re-raises it.
module regfile_write_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_reg,
    input  logic [DATA_W-1:0]        in_data,
    output logic                     reg_write,
    output logic [ADDR_W-1:0]        write_reg,
    output logic [DATA_W-1:0]        write_data,
    input  logic [ADDR_W-1:0]        query_reg1,
    input  logic [ADDR_W-1:0]        query_reg2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Entry storage; validity comes only from readPtr/count, so it is never reset.
    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];

    logic [PTR_W-1:0]  readPtr;
    logic [PTR_W-1:0]  writePtr;
    logic              doPush;
    logic              doPop;

    // Writes to $0 are acknowledged but never stored, so they cannot reach the register file.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign doPush   = in_valid && in_ready && (in_reg != '0);
    assign doPop    = (count != '0);
    assign empty    = (count == '0) && !reg_write;

    // Youngest matching pending write for one query index; MSB of the result is the hit flag.
    // The output register is oldest, then queue entries from head to tail overwrite earlier matches.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] queryReg);
        logic [DATA_W:0]  result;
        logic [PTR_W-1:0] idx;
        result = '0;
        if (queryReg != '0) begin
            if (reg_write && (write_reg == queryReg)) begin
                result = {1'b1, write_data};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = readPtr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (regMem[idx] == queryReg)) begin
                    result = {1'b1, dataMem[idx]};
                end
            end
        end
        return result;
    endfunction

    // Forwarding lookup for decode read port 1.
    always_comb begin
        {hit1, fwd_data1} = lookup(query_reg1);
    end

    // Forwarding lookup for decode read port 2.
    always_comb begin
        {hit2, fwd_data2} = lookup(query_reg2);
    end

    // Store accepted non-zero writes at the tail.
    always_ff @(posedge clock) begin
        if (doPush) begin
            regMem[writePtr]  <= in_reg;
            dataMem[writePtr] <= in_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readPtr  <= '0;
            writePtr <= '0;
            count    <= '0;
        end else begin
            if (doPush) begin
                writePtr <= writePtr + PTR_W'(1);
            end
            if (doPop) begin
                readPtr <= readPtr + PTR_W'(1);
            end
            count <= count + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Register file write port: pop the head every cycle the queue holds anything, else hold index/data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else if (doPop) begin
            reg_write  <= 1'b1;
            write_reg  <= regMem[readPtr];
            write_data <= dataMem[readPtr];
        end else begin
            reg_write  <= 1'b0;
        end
    end

endmodule
